rec_play_ctrl: RTL and testbench

- Mode controller and SRAM access sequencer for the audio recorder.
- Takes debounced record/play/stop buttons and runs the IDLE/RECORD/PLAY/PAUSE state machine.
- Owns the record and playback address pointers and the recorded-length register.
- Grants single-port SRAM cycles to the ADC write path or the DAC read path, one at a time, with fixed access timing.

---
 rtl/rec_play_ctrl_if.sv | 39 +++
 rtl/rec_play_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_rec_play_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rec_play_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : rec_play_ctrl_if
// Brief    : ADC write handshake, DAC read handshake and single-port SRAM bus
//            of the recorder mode controller.
// Revision : 1.0 - initial release
// ============================================================================
interface rec_play_ctrl_if #(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 16
);
    // ADC write path
    logic              wr_req;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ack;
    // DAC read path
    logic              rd_req;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    // SRAM bus
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_wr;
    logic              mem_rd;

    // Controller side: serves the requesters and drives the SRAM
    modport slave (
        input  wr_req, wr_data, rd_req, mem_rdata,
        output wr_ack, rd_data, rd_valid, mem_addr, mem_wdata, mem_wr, mem_rd
    );

    // Environment side: requesters plus the SRAM device
    modport master (
        output wr_req, wr_data, rd_req, mem_rdata,
        input  wr_ack, rd_data, rd_valid, mem_addr, mem_wdata, mem_wr, mem_rd
    );
endinterface
`default_nettype wire

// File: rtl/rec_play_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rec_play_ctrl
// Brief    : Recorder mode FSM (IDLE/RECORD/PLAY/PAUSE), record/playback
//            address pointers, recorded length, and a fixed-timing SRAM
//            access engine shared by the ADC write and DAC read paths.
// Revision : 1.0 - initial release
// ============================================================================
module rec_play_ctrl #(
    parameter int ADDR_W  = 18,
    parameter int DATA_W  = 16,
    parameter int ACC_CYC = 2
) (
    input  wire              clk,
    input  wire              reset,
    input  wire              record_btn,
    input  wire              play_btn,
    input  wire              stop_btn,
    rec_play_ctrl_if.slave   bus,
    output logic [1:0]       mode,
    output logic [ADDR_W-1:0] end_addr,
    output logic             done
);

    localparam int CNT_W = (ACC_CYC > 1) ? $clog2(ACC_CYC) : 1;

    localparam logic [1:0] c_MODE_IDLE  = 2'd0;
    localparam logic [1:0] c_MODE_REC   = 2'd1;
    localparam logic [1:0] c_MODE_PLAY  = 2'd2;
    localparam logic [1:0] c_MODE_PAUSE = 2'd3;

    localparam logic [0:0] c_ENG_IDLE = 1'b0;
    localparam logic [0:0] c_ENG_BUSY = 1'b1;

    // Command codes are ordered by priority so a numeric max picks the winner
    localparam logic [1:0] c_CMD_NONE = 2'd0;
    localparam logic [1:0] c_CMD_PLAY = 2'd1;
    localparam logic [1:0] c_CMD_REC  = 2'd2;
    localparam logic [1:0] c_CMD_STOP = 2'd3;

    localparam logic [ADDR_W-1:0] c_ADDR_MAX = {ADDR_W{1'b1}};

    logic              r_rec_q, r_play_q, r_stop_q;
    logic [1:0]        r_mode;
    logic [1:0]        r_pend;
    logic [0:0]        r_eng;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_is_wr;
    logic [ADDR_W-1:0] r_wr_ptr, r_rd_ptr, r_end_addr;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata, r_rd_data;
    logic              r_mem_wr, r_mem_rd;
    logic              r_wr_ack, r_rd_valid, r_done;

    logic [1:0]        w_live;
    logic [1:0]        w_cmd;
    logic              w_apply;
    logic              w_start_wr, w_start_rd;
    logic [ADDR_W-1:0] w_rd_next;

    // Resolve button edges and any held press into one command, and decide
    // whether it actually changes mode or whether an access may start instead
    always_comb begin
        w_live = c_CMD_NONE;
        if (stop_btn && !r_stop_q) begin
            w_live = c_CMD_STOP;
        end else if (record_btn && !r_rec_q) begin
            w_live = c_CMD_REC;
        end else if (play_btn && !r_play_q) begin
            w_live = c_CMD_PLAY;
        end
        w_cmd   = (r_pend > w_live) ? r_pend : w_live;
        w_apply = 1'b0;
        case (r_mode)
            c_MODE_IDLE: w_apply = (w_cmd == c_CMD_REC) ||
                                   ((w_cmd == c_CMD_PLAY) && (r_end_addr != '0));
            c_MODE_REC:  w_apply = (w_cmd == c_CMD_STOP);
            default:     w_apply = (w_cmd == c_CMD_STOP) || (w_cmd == c_CMD_PLAY);
        endcase
        w_start_wr = (r_mode == c_MODE_REC) && bus.wr_req;
        // The cycle carrying rd_valid still sees the old rd_req, so skip it
        w_start_rd = (r_mode == c_MODE_PLAY) && bus.rd_req && !r_rd_valid;
        w_rd_next  = r_rd_ptr + 1'b1;
    end

    // Mode FSM, pointers and SRAM access engine
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rec_q     <= 1'b0;
            r_play_q    <= 1'b0;
            r_stop_q    <= 1'b0;
            r_mode      <= c_MODE_IDLE;
            r_pend      <= c_CMD_NONE;
            r_eng       <= c_ENG_IDLE;
            r_cnt       <= '0;
            r_is_wr     <= 1'b0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_end_addr  <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_rd_data   <= '0;
            r_mem_wr    <= 1'b0;
            r_mem_rd    <= 1'b0;
            r_wr_ack    <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_rec_q    <= record_btn;
            r_play_q   <= play_btn;
            r_stop_q   <= stop_btn;
            r_wr_ack   <= 1'b0;
            r_rd_valid <= 1'b0;
            r_done     <= 1'b0;
            if (r_eng == c_ENG_IDLE) begin
                r_pend <= c_CMD_NONE;
                if (r_done) begin
                    // End of recording reached: playback finishes, presses dropped
                    r_mode <= c_MODE_IDLE;
                end else if (w_apply) begin
                    case (r_mode)
                        c_MODE_IDLE: begin
                            if (w_cmd == c_CMD_REC) begin
                                r_mode   <= c_MODE_REC;
                                r_wr_ptr <= '0;
                            end else begin
                                r_mode   <= c_MODE_PLAY;
                                r_rd_ptr <= '0;
                            end
                        end
                        c_MODE_REC: begin
                            r_mode     <= c_MODE_IDLE;
                            r_end_addr <= r_wr_ptr;
                        end
                        default: begin
                            if (w_cmd == c_CMD_STOP) begin
                                r_mode   <= c_MODE_IDLE;
                                r_rd_ptr <= '0;
                            end else begin
                                r_mode <= (r_mode == c_MODE_PLAY) ? c_MODE_PAUSE : c_MODE_PLAY;
                            end
                        end
                    endcase
                end else if (w_start_wr || w_start_rd) begin
                    r_eng      <= c_ENG_BUSY;
                    r_cnt      <= CNT_W'(ACC_CYC - 1);
                    r_is_wr    <= w_start_wr;
                    r_mem_addr <= w_start_wr ? r_wr_ptr : r_rd_ptr;
                    r_mem_wr   <= w_start_wr;
                    r_mem_rd   <= w_start_rd;
                    r_wr_ack   <= w_start_wr && (ACC_CYC == 1);
                    if (w_start_wr) begin
                        r_mem_wdata <= bus.wr_data;
                    end
                end
            end else begin
                // Presses during an access are parked, highest priority kept
                r_pend <= w_cmd;
                if (r_cnt != '0) begin
                    r_cnt    <= r_cnt - 1'b1;
                    r_wr_ack <= r_is_wr && (r_cnt == CNT_W'(1));
                end else begin
                    r_eng    <= c_ENG_IDLE;
                    r_mem_wr <= 1'b0;
                    r_mem_rd <= 1'b0;
                    if (r_is_wr) begin
                        if (r_wr_ptr == c_ADDR_MAX) begin
                            // Memory full: stop without wrapping the pointer
                            r_mode     <= c_MODE_IDLE;
                            r_end_addr <= c_ADDR_MAX;
                            r_pend     <= c_CMD_NONE;
                        end else begin
                            r_wr_ptr <= r_wr_ptr + 1'b1;
                        end
                    end else begin
                        r_rd_data  <= bus.mem_rdata;
                        r_rd_valid <= 1'b1;
                        r_rd_ptr   <= w_rd_next;
                        r_done     <= (w_rd_next == r_end_addr);
                    end
                end
            end
        end
    end

    assign bus.wr_ack    = r_wr_ack;
    assign bus.rd_data   = r_rd_data;
    assign bus.rd_valid  = r_rd_valid;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.mem_wr    = r_mem_wr;
    assign bus.mem_rd    = r_mem_rd;
    assign mode          = r_mode;
    assign end_addr      = r_end_addr;
    assign done          = r_done;

endmodule
`default_nettype wire

// File: tb/tb_rec_play_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_rec_play_ctrl
// Brief    : Scoreboard bench for rec_play_ctrl with a behavioural recorder
//            model, a small SRAM model and randomized button/request traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rec_play_ctrl;

    localparam int ADDR_W  = 4;
    localparam int DATA_W  = 16;
    localparam int ACC_CYC = 2;
    localparam int DEPTH   = 1 << ADDR_W;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_REC   = 2'd1;
    localparam logic [1:0] c_PLAY  = 2'd2;
    localparam logic [1:0] c_PAUSE = 2'd3;

    typedef struct packed {
        logic              is_rd;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              done;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              record_btn, play_btn, stop_btn;
    logic [1:0]        mode;
    logic [ADDR_W-1:0] end_addr;
    logic              done;

    rec_play_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    rec_play_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ACC_CYC(ACC_CYC)) dut (
        .clk        (clk),
        .reset      (reset),
        .record_btn (record_btn),
        .play_btn   (play_btn),
        .stop_btn   (stop_btn),
        .bus        (bus),
        .mode       (mode),
        .end_addr   (end_addr),
        .done       (done)
    );

    always #5 clk = ~clk;

    // SRAM device model
    logic [DATA_W-1:0] sram [DEPTH];
    always @(posedge clk) begin
        if (bus.mem_wr) sram[bus.mem_addr] <= bus.mem_wdata;
    end
    assign bus.mem_rdata = sram[bus.mem_addr];

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t exp_q[$];

    // Reference recorder state
    logic [1:0]        m_mode;
    int                m_wr_ptr, m_rd_ptr, m_end;
    logic [DATA_W-1:0] m_samples [DEPTH];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_mode = c_IDLE; m_wr_ptr = 0; m_rd_ptr = 0; m_end = 0;
    endtask

    // m = {stop, record, play}
    task automatic model_press(input logic [2:0] m);
        int cmd;
        cmd = m[2] ? 3 : m[1] ? 2 : m[0] ? 1 : 0;
        case (m_mode)
            c_IDLE: begin
                if (cmd == 2) begin m_mode = c_REC; m_wr_ptr = 0; end
                else if (cmd == 1 && m_end != 0) begin m_mode = c_PLAY; m_rd_ptr = 0; end
            end
            c_REC:   if (cmd == 3) begin m_mode = c_IDLE; m_end = m_wr_ptr; end
            c_PLAY: begin
                if (cmd == 3) begin m_mode = c_IDLE; m_rd_ptr = 0; end
                else if (cmd == 1) m_mode = c_PAUSE;
            end
            default: begin
                if (cmd == 3) begin m_mode = c_IDLE; m_rd_ptr = 0; end
                else if (cmd == 1) m_mode = c_PLAY;
            end
        endcase
    endtask

    // Returns 1 when the sample will be stored, and queues its acknowledgement
    task automatic model_write(input logic [DATA_W-1:0] d, output bit ok);
        exp_t e;
        ok = (m_mode == c_REC);
        if (ok) begin
            e.is_rd = 1'b0; e.addr = ADDR_W'(m_wr_ptr); e.data = d; e.done = 1'b0;
            exp_q.push_back(e);
            m_samples[m_wr_ptr] = d;
            if (m_wr_ptr == DEPTH - 1) begin m_mode = c_IDLE; m_end = DEPTH - 1; end
            else m_wr_ptr++;
        end
    endtask

    task automatic model_read(output bit ok);
        exp_t e;
        ok = (m_mode == c_PLAY);
        if (ok) begin
            e.is_rd = 1'b1; e.addr = ADDR_W'(m_rd_ptr); e.data = m_samples[m_rd_ptr];
            e.done  = (m_rd_ptr + 1 == m_end);
            exp_q.push_back(e);
            m_rd_ptr++;
            if (e.done) m_mode = c_IDLE;
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, "_mode"}, 32'(mode), 32'(m_mode));
        check({tag, "_end_addr"}, 32'(end_addr), 32'(m_end));
    endtask

    task automatic press(input logic [2:0] m, input string tag);
        @(negedge clk);
        stop_btn = m[2]; record_btn = m[1]; play_btn = m[0];
        repeat (2) @(negedge clk);
        stop_btn = 1'b0; record_btn = 1'b0; play_btn = 1'b0;
        repeat (2) @(negedge clk);
        model_press(m);
        check_state(tag);
    endtask

    task automatic do_write(input logic [DATA_W-1:0] d);
        bit ok;
        int seen = 0;
        model_write(d, ok);
        @(negedge clk);
        bus.wr_data = d;
        bus.wr_req  = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.wr_ack) begin seen = 1; break; end
        end
        bus.wr_req = 1'b0;
        check("wr_ack_response", 32'(seen), 32'(ok));
        @(negedge clk);
    endtask

    task automatic do_read();
        bit ok;
        int seen = 0;
        model_read(ok);
        @(negedge clk);
        bus.rd_req = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.rd_valid) begin seen = 1; break; end
        end
        bus.rd_req = 1'b0;
        check("rd_valid_response", 32'(seen), 32'(ok));
        @(negedge clk);
    endtask

    // Monitor: strobe timing and scoreboard pops, sampled just after each edge
    initial begin : monitor
        int                run_len  = 0;
        logic [ADDR_W-1:0] run_addr = '0;
        exp_t              e;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                run_len = 0;
            end else begin
                if (bus.mem_wr || bus.mem_rd) begin
                    if (run_len == 0) run_addr = bus.mem_addr;
                    else check("mem_addr_stable", 32'(bus.mem_addr), 32'(run_addr));
                    run_len++;
                end else if (run_len != 0) begin
                    check("strobe_length", 32'(run_len), 32'(ACC_CYC));
                    run_len = 0;
                end
                if (bus.wr_ack) begin
                    check("wr_ack_expected", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("wr_kind", 32'(e.is_rd), 32'd0);
                        check("wr_strobe", 32'(bus.mem_wr), 32'd1);
                        check("wr_addr", 32'(bus.mem_addr), 32'(e.addr));
                        check("wr_data", 32'(bus.mem_wdata), 32'(e.data));
                    end
                end
                if (bus.rd_valid) begin
                    check("rd_valid_expected", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("rd_kind", 32'(e.is_rd), 32'd1);
                        check("rd_addr", 32'(run_addr), 32'(e.addr));
                        check("rd_data", 32'(bus.rd_data), 32'(e.data));
                        check("rd_done", 32'(done), 32'(e.done));
                    end
                end
                if (done) check("done_with_rd_valid", 32'(bus.rd_valid), 32'd1);
            end
        end
    end

    initial begin : stimulus
        bit ok;
        int seen;
        reset = 1'b1;
        record_btn = 1'b0; play_btn = 1'b0; stop_btn = 1'b0;
        bus.wr_req = 1'b0; bus.rd_req = 1'b0; bus.wr_data = '0;
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_mode", 32'(mode), 32'(c_IDLE));
        check("rst_end_addr", 32'(end_addr), 32'd0);
        check("rst_mem_wr", 32'(bus.mem_wr), 32'd0);
        check("rst_mem_rd", 32'(bus.mem_rd), 32'd0);
        check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        check("rst_rd_data", 32'(bus.rd_data), 32'd0);
        check("rst_acks", 32'({bus.wr_ack, bus.rd_valid, done}), 32'd0);

        // Record four samples, stop
        press(3'b010, "rec1");
        for (int i = 1; i <= 4; i++) do_write(DATA_W'(16'h1111 * i));
        press(3'b100, "stop1");

        // Full playback ending in done
        press(3'b001, "play1");
        for (int i = 0; i < 4; i++) do_read();
        check_state("after_done");

        // Pause and resume at the held pointer
        press(3'b001, "play2");
        do_read(); do_read();
        press(3'b001, "pause");
        do_read();
        press(3'b001, "resume");
        do_read(); do_read();
        check_state("after_resume");

        // Stop during an in-flight write keeps that sample
        press(3'b010, "rec2");
        do_write(16'hA001); do_write(16'hA002);
        model_write(16'hA003, ok);
        @(negedge clk);
        bus.wr_data = 16'hA003; bus.wr_req = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.mem_wr) begin seen = 1; break; end
        end
        check("midwr_strobe_seen", 32'(seen), 32'd1);
        stop_btn = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.wr_ack) begin seen = 1; break; end
            @(negedge clk);
        end
        bus.wr_req = 1'b0;
        check("midwr_ack_seen", 32'(seen), 32'd1);
        @(negedge clk);
        stop_btn = 1'b0;
        repeat (3) @(negedge clk);
        model_press(3'b100);
        check_state("midwr_stop");

        // Stop and record together: stop wins
        press(3'b010, "rec3");
        do_write(16'hB001);
        press(3'b110, "stop_rec_same");

        // Reset in the middle of a read
        press(3'b001, "play3");
        @(negedge clk);
        bus.rd_req = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.mem_rd) begin seen = 1; break; end
        end
        check("rst_rd_strobe_seen", 32'(seen), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("midrd_mem_rd", 32'(bus.mem_rd), 32'd0);
        check("midrd_mode", 32'(mode), 32'(c_IDLE));
        check("midrd_end_addr", 32'(end_addr), 32'd0);
        reset = 1'b0; bus.rd_req = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);

        // Play with nothing recorded is ignored
        press(3'b001, "play_empty");

        // Fill the whole memory: auto-stop, no wrap
        press(3'b010, "rec_full");
        for (int i = 0; i < DEPTH; i++) do_write(DATA_W'($urandom));
        check_state("auto_stop");
        do_write(16'hDEAD);
        press(3'b001, "play_full");
        for (int i = 0; i < DEPTH - 1; i++) do_read();
        check_state("play_full_done");

        // Randomized traffic
        for (int n = 0; n < 80; n++) begin
            int op;
            op = $urandom_range(0, 9);
            if (op <= 1)      press(3'(1 << $urandom_range(0, 2)), "rnd_press");
            else if (op == 2) press(3'($urandom_range(1, 7)), "rnd_multi");
            else if (op <= 5) do_write(DATA_W'($urandom));
            else              do_read();
        end

        repeat (4) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
